fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the pipelined datapath. It keeps its own shadow pipeline of destination-register info from EX through the last forwarding stage. It latches the EX-stage source registers and generates per-operand forward selects for any depth. It also inserts a configurable number of load-use bubbles via a stall counter, and honours pipeline advance and flush.

Parameters:
FWD_DEPTH, 2, number of post-EX stages that can forward (1 = MEM, 2 = WB, ...); range 1..7
LOAD_LAT, 1, bubbles inserted on a load-use hazard; range 1..4
SEL_W, $clog2(FWD_DEPTH+1), derived width of forward selects; not overridable

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
pipe_en  input  1  pipeline advances this cycle
flush  input  1  squash ID->EX transfer (branch/jump resolved)
id_valid  input  1  ID holds a real instruction
id_rs  input  5  ID source register A
id_rt  input  5  ID source register B
id_i_type  input  1  ID operand B is an immediate
id_wsel  input  5  ID destination register
id_regwrite  input  1  ID instruction writes the register file
id_memread  input  1  ID instruction is a load
fwd_sel_a  output  SEL_W  EX operand A source: 0 = register file, k = stage k
fwd_sel_b  output  SEL_W  EX operand B source, same encoding
stall  output  1  hold PC and IF/ID; bubble into EX

Behaviour:
- Reset (async, nRST=0): all shadow entries invalid; ex_rs, ex_rt, ex_i_type, stall counter cleared. Outputs fwd_sel_a=0, fwd_sel_b=0, stall=0.
- Shadow entry fields: valid, wsel, regwrite, memread. Entries are 0..FWD_DEPTH (0 = EX).
- Advance (pipe_en=1, rising CLK):
  - entry[k+1] <= entry[k] for k = 0..FWD_DEPTH-1.
  - entry[0] <= bubble (valid=0) if flush or stall; otherwise the ID fields.
  - ex_rs/ex_rt/ex_i_type follow the same rule; a bubble loads 0.
- pipe_en=0: all state holds; outputs are recomputed from the held state.
- Forward select (combinational from state), operand A:
  - k = smallest index 1..FWD_DEPTH where entry[k] is valid, regwrite=1, wsel!=0 and wsel==ex_rs; else 0.
  - Nearest stage wins when several match.
- Operand B: same rule against ex_rt; forced to 0 when ex_i_type=1.
- Register 0 never forwards.
- Hazard hz (combinational): id_valid, and entry[0] is valid with memread=1, regwrite=1, wsel!=0, and wsel matches id_rs, or id_rt when id_i_type=0.
- stall = (hz | cnt!=0) & ~flush.
- Stall counter cnt, width 2 bits min.
  - On advance with hz & cnt==0 & ~flush: cnt <= LOAD_LAT-1.
  - On advance with cnt!=0: cnt <= cnt-1.
  - flush & pipe_en: cnt <= 0. Flush overrides stall because the ID instruction is discarded.
- LOAD_LAT=1 gives exactly one bubble; counter never loads nonzero.
- Simultaneous hz on a new instruction while cnt!=0 cannot occur (ID held); cnt takes priority.
- Reset mid-stall: cnt and entries cleared immediately; stall drops asynchronously.

Optional Feature:
FWD_HAZARD_STATS_EN
- Defined:
  - Adds outputs stall_cycles[15:0] and fwd_count[15:0], both saturating at 16'hFFFF and cleared by nRST.
  - stall_cycles increments each CLK with stall=1 and pipe_en=1.
  - fwd_count increments by the number of nonzero selects (0, 1 or 2) each advance.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset -> assert nRST=0 mid-operation with entries full -> fwd_sel_a=fwd_sel_b=0 and stall=0 immediately; hold 3 cycles after release.
- EX->MEM forward: advance ADD $3 (wsel=3, regwrite=1), then SUB rs=3 rt=4 -> fwd_sel_a=1, fwd_sel_b=0 while SUB is in EX.
- Priority: ADD $5, ADD $5, then OR rs=5 rt=5 (FWD_DEPTH=2) -> fwd_sel_a=1, fwd_sel_b=1. Same with OR i_type=1 -> fwd_sel_b=0.
- Load-use, LOAD_LAT=1: LW $7 in EX, ID rs=7 -> stall=1 for exactly 1 advance, one bubble. Then fwd_sel_a=2 when the consumer reaches EX.
- Load-use, LOAD_LAT=3, FWD_DEPTH=4: LW $9, ID rt=9 rtype -> stall high for 3 advances. pipe_en=0 during stall extends it without consuming counts.
- Flush during stall: LW $2, ID rs=2, LOAD_LAT=3, flush on the second stall cycle -> stall=0 that cycle, cnt=0, entry[0] bubble. Zero-register: ADD $0 then rs=0 -> fwd_sel_a=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit: shadow pipeline of destination info from EX onward,
// per-operand forward selects and a load-use stall counter. `define FWD_HAZARD_STATS_EN adds counters.
module fwd_hazard_unit #(
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pipe_en,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_i_type,
  input  logic [4:0]       id_wsel,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      fwd_count
`endif
);

  localparam int CNT_W = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] wsel;
    logic       regwrite;
    logic       memread;
  } shadow_t;

  shadow_t           entry_q [0:FWD_DEPTH];
  logic [4:0]        ex_rs_q;
  logic [4:0]        ex_rt_q;
  logic              ex_i_type_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hz;

  // A load in EX that writes a register the ID instruction reads.
  assign hz = id_valid && entry_q[0].valid && entry_q[0].memread && entry_q[0].regwrite &&
              (entry_q[0].wsel != 5'd0) &&
              ((entry_q[0].wsel == id_rs) || (!id_i_type && (entry_q[0].wsel == id_rt)));

  assign stall = (hz || (cnt_q != '0)) && !flush;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    // Walk from the farthest stage inwards so the nearest match is the last one written.
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (entry_q[k].valid && entry_q[k].regwrite && (entry_q[k].wsel != 5'd0)) begin
        if (entry_q[k].wsel == ex_rs_q) fwd_sel_a = SEL_W'(k);
        if (entry_q[k].wsel == ex_rt_q) fwd_sel_b = SEL_W'(k);
      end
    end
    if (ex_i_type_q) fwd_sel_b = '0;
  end

  // NOTE: the shadow array is small and its valid bits must read clear straight out of reset, so every entry is reset rather than left as uninitialised storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k <= FWD_DEPTH; k++) entry_q[k] <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_i_type_q <= 1'b0;
      cnt_q       <= '0;
    end else if (pipe_en) begin
      // NOTE: non-blocking assignments let the shift read the pre-edge values of every entry regardless of statement order.
      for (int k = 0; k < FWD_DEPTH; k++) entry_q[k+1] <= entry_q[k];
      if (flush || stall) begin
        entry_q[0]  <= '0;
        ex_rs_q     <= '0;
        ex_rt_q     <= '0;
        ex_i_type_q <= 1'b0;
      end else begin
        entry_q[0]  <= '{valid: id_valid, wsel: id_wsel, regwrite: id_regwrite, memread: id_memread};
        ex_rs_q     <= id_rs;
        ex_rt_q     <= id_rt;
        ex_i_type_q <= id_i_type;
      end
      // Flush discards the waiting consumer, so any remaining bubbles are pointless.
      if (flush)              cnt_q <= '0;
      else if (cnt_q != '0)   cnt_q <= cnt_q - CNT_W'(1);
      else if (hz)            cnt_q <= CNT_W'(LOAD_LAT - 1);
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [1:0]  fwd_inc;
  logic [16:0] fwd_sum;

  assign fwd_inc = {1'b0, (fwd_sel_a != '0)} + {1'b0, (fwd_sel_b != '0)};
  assign fwd_sum = {1'b0, fwd_count} + {15'd0, fwd_inc};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      fwd_count    <= '0;
    end else if (pipe_en) begin
      if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      fwd_count <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: two instances (depth 2 / latency 1, depth 4 / latency 3)
// share stimulus; each scenario resets and checks the instance it targets.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pipe_en, flush, id_valid, id_i_type, id_regwrite, id_memread;
  logic [4:0] id_rs, id_rt, id_wsel;

  logic [1:0] sel_a_a, sel_b_a;
  logic       stall_a;
  logic [2:0] sel_a_b, sel_b_b;
  logic       stall_b;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cycles_a, fwd_count_a, stall_cycles_b, fwd_count_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.FWD_DEPTH(2), .LOAD_LAT(1)) u_a (
    .CLK(clk), .nRST(rst_n), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_i_type(id_i_type), .id_wsel(id_wsel),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .fwd_sel_a(sel_a_a), .fwd_sel_b(sel_b_a), .stall(stall_a)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles_a), .fwd_count(fwd_count_a)
`endif
  );

  fwd_hazard_unit #(.FWD_DEPTH(4), .LOAD_LAT(3)) u_b (
    .CLK(clk), .nRST(rst_n), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_i_type(id_i_type), .id_wsel(id_wsel),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .fwd_sel_a(sel_a_b), .fwd_sel_b(sel_b_b), .stall(stall_b)
`ifdef FWD_HAZARD_STATS_EN
    , .stall_cycles(stall_cycles_b), .fwd_count(fwd_count_b)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic it,
                        input logic [4:0] ws, input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_i_type = it;
    id_wsel = ws; id_regwrite = rw; id_memread = mr;
    #2;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic priority_case(input logic it, input string tag);
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd5, it,   5'd8, 1'b1, 1'b0); tick();
    nop();
    check({tag, "_sel_a"}, sel_a_a, 1);
    check({tag, "_sel_b"}, sel_b_a, it ? 0 : 1);
  endtask

  initial begin
    rst_n = 1'b0; pipe_en = 1'b0; flush = 1'b0;
    nop();
    check("reset_sel_a", sel_a_a, 0);
    check("reset_sel_b", sel_b_a, 0);
    check("reset_stall", stall_a, 0);

    // EX->MEM forward of operand A only.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b0, 5'd6, 1'b1, 1'b0);
    check("mem_fwd_no_stall", stall_a, 0);
    tick();
    nop();
    check("mem_fwd_sel_a", sel_a_a, 1);
    check("mem_fwd_sel_b", sel_b_a, 0);
    pipe_en = 1'b0; tick();
    check("hold_sel_a", sel_a_a, 1);
    pipe_en = 1'b1;

    // Nearest stage wins; immediate operand B never forwards.
    priority_case(1'b0, "prio_rtype");
    priority_case(1'b1, "prio_itype");

    // Producer two stages ahead forwards from WB.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(1'b1, 5'd6, 5'd5, 1'b0, 5'd8, 1'b1, 1'b0); tick();
    nop();
    check("wb_fwd_sel_a", sel_a_a, 0);
    check("wb_fwd_sel_b", sel_b_a, 2);

    // Load-use with one bubble.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd7, 5'd3, 1'b0, 5'd10, 1'b1, 1'b0);
    check("lu1_stall_first", stall_a, 1);
    tick();
    check("lu1_stall_done", stall_a, 0);
    check("lu1_bubble_sel_a", sel_a_a, 0);
    tick();
    nop();
    check("lu1_fwd_wb", sel_a_a, 2);
`ifdef FWD_HAZARD_STATS_EN
    check("lu1_stat_stall", stall_cycles_a, 1);
    check("lu1_stat_fwd0", fwd_count_a, 0);
    tick();
    check("lu1_stat_fwd1", fwd_count_a, 1);
`endif

    // Load-use with three bubbles; a held pipeline does not consume counts.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd1, 5'd9, 1'b0, 5'd11, 1'b1, 1'b0);
    check("lu3_stall_adv1", stall_b, 1);
    tick();
    check("lu3_stall_adv2", stall_b, 1);
    pipe_en = 1'b0;
    tick(); tick();
    check("lu3_stall_held", stall_b, 1);
    pipe_en = 1'b1;
    tick();
    check("lu3_stall_adv3", stall_b, 1);
    tick();
    check("lu3_stall_released", stall_b, 0);
    tick();
    nop();
    check("lu3_fwd_sel_b", sel_b_b, 4);
    check("lu3_fwd_sel_a", sel_a_b, 0);

    // Flush on the second stall cycle kills the remaining bubbles.
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 5'd2, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd2, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    check("flush_stall_first", stall_b, 1);
    tick();
    flush = 1'b1; #1;
    check("flush_masks_stall", stall_b, 0);
    tick();
    flush = 1'b0; #1;
    check("flush_cnt_cleared", stall_b, 0);
    check("flush_bubble_sel_a", sel_a_b, 0);

    // Register 0 neither forwards nor causes a load-use stall.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); tick();
    nop();
    check("zero_reg_sel_a", sel_a_a, 0);
    check("zero_reg_sel_b", sel_b_a, 0);
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    check("zero_reg_no_stall", stall_a, 0);

    // Asynchronous reset with a forward and a stall both active.
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 5'd7, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd7, 5'd5, 1'b0, 5'd13, 1'b1, 1'b0);
    check("pre_rst_sel_a", sel_a_a, 1);
    check("pre_rst_stall", stall_a, 1);
    rst_n = 1'b0; #1;
    check("async_rst_sel_a", sel_a_a, 0);
    check("async_rst_sel_b", sel_b_a, 0);
    check("async_rst_stall", stall_a, 0);
    tick();
    @(negedge clk); rst_n = 1'b1;
    nop();
    repeat (3) tick();
    check("post_rst_sel_a", sel_a_a, 0);
    check("post_rst_stall", stall_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
